// File: rtl/bcd_scan_controller_if.sv
// Bus between the BCD counter core and the display scan controller.
// The master drives digits and display options; the slave drives the scanned segment outputs.
interface bcd_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int SEL_W = $clog2(NUM_DIGITS);

  logic                    ena;
  logic [4*NUM_DIGITS-1:0] digits_bcd;
  logic                    lz_suppress;
  logic                    dp_en;
  logic [SEL_W-1:0]        dp_sel;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_start;

  modport master (
    output ena, digits_bcd, lz_suppress, dp_en, dp_sel,
    input  seg_out, dp_out, digit_en, frame_start
  );

  modport slave (
    input  ena, digits_bcd, lz_suppress, dp_en, dp_sel,
    output seg_out, dp_out, digit_en, frame_start
  );
endinterface

// File: rtl/bcd_scan_controller.sv
// Time-multiplexes snapshotted BCD digits onto one 7-segment bus with per-slot blanking,
// leading-zero suppression, decimal point and a dash for invalid codes.
//
// state  | meaning
// S_IDLE | scan stopped, all outputs 0
// S_SCAN | stepping through digit slots; each slot is BLANK then SHOW
module bcd_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_scan_controller_if.slave   bus
);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_SHOW  = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic                    dp_en_q, dp_en_d;
  logic [IDX_W-1:0]        dp_sel_q, dp_sel_d;
  logic                    load;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    fs_q, fs_d;

  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              cur;
  logic [6:0]              dec;
  logic                    acc, sup_here, show, suppress, lit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      idx_q    <= '0;
      snap_q   <= '0;
      dp_en_q  <= 1'b0;
      dp_sel_q <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      en_q     <= '0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      dp_en_q  <= dp_en_d;
      dp_sel_q <= dp_sel_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      en_q     <= en_d;
      fs_q     <= fs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    dp_en_d  = dp_en_q;
    dp_sel_d = dp_sel_q;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ena) begin
          state_d = S_SCAN;
          slot_d  = '0;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      S_SCAN: begin
        if (!bus.ena) begin
          state_d = S_IDLE;
          slot_d  = '0;
          idx_d   = '0;
        end else if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            load  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Snapshot and dp latches reload together so a frame never mixes old and new values.
    if (load) begin
      snap_d   = bus.digits_bcd;
      dp_en_d  = bus.dp_en;
      dp_sel_d = bus.dp_sel;
    end
  end

  // Outputs are computed from next-state values so the registered outputs line up with the slot they describe.
  always_comb begin
    acc        = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc           = acc && (snap_d[4*i +: 4] == 4'd0);
      upper_zero[i] = acc;
    end

    cur      = 4'd0;
    onehot   = '0;
    sup_here = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        cur       = snap_d[4*i +: 4];
        onehot[i] = 1'b1;
        sup_here  = upper_zero[i];
      end
    end

    case (cur)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h40;
    endcase

    show     = (state_d == S_SCAN) && (slot_d >= SLOT_SHOW);
    suppress = bus.lz_suppress && (idx_d != '0) && sup_here;
    lit      = show && !suppress;

    seg_d = lit ? dec : 7'h00;
    en_d  = lit ? onehot : '0;
    dp_d  = lit && dp_en_d && (dp_sel_d == idx_d);
    fs_d  = (state_d == S_SCAN) && (slot_d == '0) && (idx_d == '0);
  end

  assign bus.seg_out     = seg_q;
  assign bus.dp_out      = dp_q;
  assign bus.digit_en    = en_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_bcd_scan_controller.sv
// Scoreboard bench for bcd_scan_controller (4 digits, 8-cycle slots, 2 blank cycles).
// Stimulus queues expected per-cycle outputs; a negedge monitor compares them.
module tb_bcd_scan_controller;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    int          cyc;
    logic [12:0] v;   // {frame_start, digit_en[3:0], dp_out, seg_out[6:0]}
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  bcd_scan_controller_if #(.NUM_DIGITS(4)) bus ();

  bcd_scan_controller #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [12:0] got;
    exp_t        e;
    got = {bus.frame_start, bus.digit_en, bus.dp_out, bus.seg_out};
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s cyc %0d: expectation skipped, now at cyc %0d", e.tag, e.cyc, cyc);
      end else if (got !== e.v) begin
        errors++;
        $display("FAIL %s cyc %0d: got fs=%b en=%b dp=%b seg=%h, expected fs=%b en=%b dp=%b seg=%h",
                 e.tag, cyc, got[12], got[11:8], got[7], got[6:0],
                 e.v[12], e.v[11:8], e.v[7], e.v[6:0]);
      end
    end
  end

  task automatic push_slot(input int base, input int d, input logic [6:0] seg,
                           input logic dp, input logic supp, input int ncyc, input string tag);
    exp_t e;
    logic lit;
    for (int k = 0; k < ncyc; k++) begin
      lit   = (k >= 2) && !supp;
      e.cyc = base + k;
      e.v   = {(k == 0 && d == 0), lit ? 4'(1 << d) : 4'b0000, lit && dp, lit ? seg : 7'h00};
      e.tag = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] supp, input int dp_digit, input string tag);
    push_slot(base,      0, s0, dp_digit == 0, supp[0], 8, tag);
    push_slot(base + 8,  1, s1, dp_digit == 1, supp[1], 8, tag);
    push_slot(base + 16, 2, s2, dp_digit == 2, supp[2], 8, tag);
    push_slot(base + 24, 3, s3, dp_digit == 3, supp[3], 8, tag);
  endtask

  task automatic push_zero(input int from, input int n, input string tag);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc = from + k;
      e.v   = '0;
      e.tag = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int b, b2, b3, b4, b5, b6, b7, b8, d, r, guard;
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.ena         = 1'b0;
    bus.digits_bcd  = 16'h0000;
    bus.lz_suppress = 1'b0;
    bus.dp_en       = 1'b0;
    bus.dp_sel      = 2'd0;

    @(posedge clk);
    #1;
    push_zero(cyc + 1, 2, "reset");
    wait_until(3);

    // reset and enable released together: frame starts on the next cycle
    rst_n          = 1'b1;
    bus.ena        = 1'b1;
    bus.digits_bcd = 16'h1234;
    b = cyc + 1;
    push_frame(b,      7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, -1, "basic");
    push_frame(b + 32, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, -1, "basic_repeat");

    b2 = b + 64;
    wait_until(b2 - 1);
    bus.digits_bcd  = 16'h0050;
    bus.lz_suppress = 1'b1;
    push_frame(b2, 7'h3F, 7'h6D, 7'h00, 7'h00, 4'b1100, -1, "lead_zero");

    b3 = b2 + 32;
    wait_until(b3 - 1);
    bus.digits_bcd = 16'h0000;
    push_frame(b3, 7'h3F, 7'h00, 7'h00, 7'h00, 4'b1110, -1, "all_zero");

    b4 = b3 + 32;
    wait_until(b4 - 1);
    bus.digits_bcd  = 16'h1234;
    bus.lz_suppress = 1'b0;
    push_frame(b4, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, -1, "no_tear");
    wait_until(b4 + 12);
    bus.digits_bcd = 16'h9876;

    b5 = b4 + 32;
    push_frame(b5, 7'h7D, 7'h07, 7'h7F, 7'h6F, 4'b0000, -1, "new_snapshot");

    b6 = b5 + 32;
    wait_until(b6 - 1);
    bus.digits_bcd = 16'hB1F0;
    bus.dp_en      = 1'b1;
    bus.dp_sel     = 2'd2;
    push_frame(b6, 7'h3F, 7'h40, 7'h06, 7'h40, 4'b0000, 2, "invalid_dp");

    // enable drop in slot-2 SHOW, then restart three cycles later
    b7 = b6 + 32;
    d  = b7 + 19;
    push_slot(b7,      0, 7'h3F, 1'b0, 1'b0, 8, "ena_drop");
    push_slot(b7 + 8,  1, 7'h40, 1'b0, 1'b0, 8, "ena_drop");
    push_slot(b7 + 16, 2, 7'h06, 1'b1, 1'b0, 4, "ena_drop");
    push_zero(d + 1, 3, "ena_low");
    wait_until(d);
    bus.ena = 1'b0;
    wait_until(d + 3);
    bus.ena = 1'b1;

    // reset asserted in slot 1 while enabled
    b8 = d + 4;
    r  = b8 + 13;
    push_slot(b8,     0, 7'h3F, 1'b0, 1'b0, 8, "restart");
    push_slot(b8 + 8, 1, 7'h40, 1'b0, 1'b0, 6, "restart");
    push_zero(r + 1, 2, "mid_reset");
    wait_until(r);
    rst_n = 1'b0;
    wait_until(r + 2);
    rst_n = 1'b1;
    push_frame(r + 3, 7'h3F, 7'h40, 7'h06, 7'h40, 4'b0000, 2, "post_reset");

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_scan_controller.md
# bcd_scan_controller

Display scan controller for the BCD counter datapath in `tt_um_bcd_counter`. It takes the counter's packed BCD digits and time-multiplexes them onto one shared 7-segment bus with one-hot digit enables. Digits are snapshotted once per frame so the display never tears, and a blanking interval precedes each digit to prevent ghosting. Leading-zero suppression, a decimal point and invalid-code display are included. It sits between the counter core and the `uo_out`/`uio_out` pins.

## Interface
- `NUM_DIGITS`, 4, number of BCD digits scanned; must be ≥2.
- `SCAN_DIV`, 1000, clock cycles per digit slot; must be ≥2.
- `BLANK_CYCLES`, 16, blanked cycles at the start of each slot.
  - Constraint: 0 ≤ `BLANK_CYCLES` < `SCAN_DIV`.
  - 0 means no blanking.

- `clk` in 1: system clock; the block is single-clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `ena` in 1: scan enable.
- `digits_bcd` in 4*NUM_DIGITS: packed digits; digit i = bits [4i+3:4i], digit 0 least significant.
- `lz_suppress` in 1: blank leading zeros.
- `dp_en` in 1: decimal point enable.
- `dp_sel` in clog2(NUM_DIGITS): index of the digit that carries the decimal point.
- `seg_out` out 7: segments {g,f,e,d,c,b,a}, active high.
- `dp_out` out 1: decimal point segment, active high.
- `digit_en` out NUM_DIGITS: one-hot digit select, active high.
- `frame_start` out 1: one-cycle pulse marking the first cycle of the digit-0 slot.

## Operation
- States:
  - IDLE: all outputs 0.
  - SCAN: has two phases per slot.
    - BLANK phase: slot count < `BLANK_CYCLES`.
    - SHOW phase: slot count ≥ `BLANK_CYCLES`.
- Internal registers:
  - slot counter, 0..SCAN_DIV-1.
  - digit index, 0..NUM_DIGITS-1.
  - snapshot register, 4*NUM_DIGITS bits.
  - dp latches: `dp_en`/`dp_sel` are captured together with the snapshot.
- IDLE→SCAN: on an edge where `rst_n`=1 and `ena`=1.
  - Digit index is set to 0 and slot count to 0.
  - The snapshot loads `digits_bcd`.
- In SCAN, the slot counter increments every cycle. At SCAN_DIV-1 it returns to 0 and the digit index increments.
  - When the index wraps from NUM_DIGITS-1 to 0, the snapshot and dp latches reload on that same edge.
- SCAN→IDLE: on any edge where `ena`=0. All counters clear.
- Segment decode, applied to the snapshot digit:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - codes 10–15 = 0x40 (dash)
- Leading-zero suppression: when `lz_suppress`=1, digit i (i≥1) is suppressed if snapshot digits i..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed.
  - A suppressed digit outputs `digit_en`=0, `seg_out`=0 and `dp_out`=0 for its whole slot.
  - Its slot time is still consumed, so the frame period is unchanged.
- BLANK phase: `digit_en`=0, `seg_out`=0, `dp_out`=0.
- SHOW phase:
  - `digit_en` is one-hot at the current index.
  - `seg_out` is the decoded digit.
  - `dp_out` = latched `dp_en` AND (latched `dp_sel` == index).
  - If the latched `dp_sel` ≥ NUM_DIGITS, `dp_out` stays 0.

## Timing
- All outputs are registered. On reset they are 0 and the state is IDLE.
- Latency: after the edge taking IDLE→SCAN, the next cycle is slot 0, cycle 0, and `frame_start`=1 in that cycle.
- `frame_start` is high only on cycle 0 of every digit-0 slot.
- Frame period = NUM_DIGITS × SCAN_DIV cycles.
- The first SHOW cycle of a slot is cycle `BLANK_CYCLES`. The slot's last cycle is SCAN_DIV-1.
- Changes to `digits_bcd`, `lz_suppress`, `dp_en` or `dp_sel` mid-frame have no effect until the next snapshot.
  - Exception: `lz_suppress` is sampled live, not snapshotted.
- `ena` low mid-slot: all outputs are 0 in the cycle after the edge.
- `ena` high again: the scan restarts at digit 0 with `frame_start`. There is no resume.
- `rst_n` low overrides `ena`: next cycle all outputs are 0 and the state is IDLE.
- Reset and `ena` released together: the first edge with both high starts a frame.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.

- **Basic scan:** `digits_bcd`=0x1234, `ena`=1, `lz_suppress`=0.
  - `frame_start` is high on slot 0, cycle 0.
  - Cycles 0–1: `digit_en`=0.
  - Cycles 2–7: `digit_en`=0001, `seg_out`=0x66.
  - Next slot shows 0010/0x4F, then 0100/0x5B, then 1000/0x06.
  - `frame_start` repeats every 32 cycles.
- **Leading zeros:** `digits_bcd`=0x0050, `lz_suppress`=1.
  - Slots 2 and 3: `digit_en`=0, `seg_out`=0.
  - Slot 1: 0x6D. Slot 0: 0x3F.
  - With 0x0000, only digit 0 lights, showing 0x3F.
- **Tearing and invalid codes:**
  - Change `digits_bcd` from 0x1234 to 0x9876 during the slot-1 SHOW phase. Slots 1–3 still show 3, 2, 1. The next frame shows 6, 7, 8, 9.
  - Nibble 0xB displays 0x40.
- **Decimal point:** `dp_en`=1, `dp_sel`=2. `dp_out`=1 only in the SHOW cycles of slot 2, and 0 during BLANK.
- **Enable drop and restart:** drop `ena` during a slot-2 SHOW cycle. The next cycle has all outputs 0. Raise `ena` three cycles later: `frame_start` is asserted and digit 0 is in BLANK one cycle after the edge.
- **Reset mid-frame:** assert `rst_n`=0 during slot 1 with `ena`=1. All outputs are 0 on the next cycle. On release, a frame starts one cycle after the first edge with `rst_n`=1.
